ks_add_sched: RTL and testbench
===============================

# ks_add_sched

Issue scheduler for the shared pipelined 24-bit Kogge-Stone adder. Arbitrates two requesters (mantissa-add path = 0, rounding/normalise path = 1) round-robin onto the single adder port. Tracks in-flight operations with a tag pipeline matched to the adder's fixed latency and routes each sum back to its owner in issue order. Optionally sequences 48-bit adds as two chained 24-bit passes, carrying the low-half carry-out into the high-half carry-in.

## Interface
- WIDTH, 24, adder operand width.
- LAT, 3, fixed adder latency in cycles from `o_add_valid` to `i_add_sum`; legal range 1..8.
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_reqN_valid  in  1  request from requester N (N = 0, 1).
- o_reqN_ready  out  1  request accepted on this edge when high with valid.
- i_reqN_a, i_reqN_b  in  2*WIDTH  operands; upper WIDTH ignored for narrow ops.
- i_reqN_cin  in  1  carry-in.
- i_reqN_wide  in  1  request is a 48-bit chained add.
- o_add_valid  out  1  operands on the adder port are valid.
- o_add_a, o_add_b  out  WIDTH  adder operands (registered).
- o_add_cin  out  1  adder carry-in (registered).
- i_add_sum  in  WIDTH  adder sum, LAT cycles after matching `o_add_valid`.
- i_add_cout  in  1  adder carry-out, aligned with `i_add_sum`.
- o_rsp_valid  out  1  response valid; one cycle wide; no backpressure.
- o_rsp_id  out  1  owning requester.
- o_rsp_sum  out  2*WIDTH  result; upper WIDTH zero for narrow ops.
- o_rsp_cout  out  1  final carry-out.

## Operation
- States: ISSUE, WIDE_WAIT, WIDE_HI.
- ISSUE: grant = single valid requester, or, if both valid, the one not granted last. `o_reqN_ready` = grant (combinational from valids and pointer). Pointer updates only on accept.
- Narrow accept: operands, cin registered onto adder port next cycle. Tag {valid, id, wide, half} pushed into a LAT-deep shift register alongside.
- Wide accept: low halves issued as above (half = low). Upper operands and id latched. State -> WIDE_WAIT. Both readies low.
- WIDE_WAIT: no issue. When the low-half tag exits, capture `i_add_sum` into low register and `i_add_cout` as high carry-in; state -> WIDE_HI.
- WIDE_HI: issue upper halves with captured carry (half = high). State -> ISSUE the same edge. Readies stay low this cycle.
- Tag exit: narrow -> response {0, sum}; high half -> response {sum, low register}; low half -> no response.
- Responses leave strictly in issue order, at most one per cycle. Narrow ops in flight when a wide op is accepted complete normally ahead of it.
- `i_add_*` is sampled only when the exiting tag is valid. Other values are ignored.

## Timing
- Reset: all outputs 0; state ISSUE; tags cleared; pointer set so requester 0 wins the first tie; low register 0.
- Narrow: accept at edge t -> `o_add_valid` t+1 -> sum t+1+LAT -> `o_rsp_valid` t+2+LAT. Throughput 1/cycle.
- Wide: accept t -> low issue t+1 -> high issue t+2+LAT -> `o_rsp_valid` t+3+2*LAT. Next accept earliest at edge t+3+LAT.
- Reset mid-operation clears tags and state. Adder results arriving after reset are dropped. No response is emitted for pre-reset requests.
- Valid deasserted without ready: legal. Operand stability is not required.

## Configuration
- KS_ADD_SCHED_WIDE_EN defined: wide ops, WIDE_WAIT/WIDE_HI and low register are present.
- Undefined: `i_reqN_wide` is ignored and every request is narrow. The FSM is reduced to ISSUE. `o_rsp_sum[2*WIDTH-1:WIDTH]` is tied to 0.

## Test plan
- Single narrow: req0 a=0x000FFF, b=0x000001, cin=0 -> `o_rsp_valid` at t+5 (LAT=3), id=0, sum=0x001000, cout=0.
- Tie: both valid every cycle for 4 cycles -> grants 0,1,0,1. Responses 1 per cycle, same order, correct ids.
- Carry out: req1 a=0xFFFFFF, b=0x000001 -> sum=0, cout=1, id=1.
- Wide (macro on): req0 a=0x000001_FFFFFF, b=0x000000_000001 -> high issued with cin=1. Response at t+9, sum=0x000002_000000, cout=0. Readies low t..t+5.
- Wide with prior narrow in flight: req1 narrow then req0 wide next cycle -> req1 response first, then wide. No overlap.
- Reset after accepting 2 narrow ops, before results -> no `o_rsp_valid` ever. Next request after reset completes normally; req0 wins tie.

Source files
------------

// File: rtl/ks_add_sched.sv
// ks_add_sched: round-robin issue scheduler for the shared pipelined Kogge-Stone adder.
// Define KS_ADD_SCHED_WIDE_EN to enable 48-bit adds sequenced as two chained passes.
module ks_add_sched #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned LAT   = 3
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_req0_valid,
   output logic               o_req0_ready,
   input  logic [2*WIDTH-1:0] i_req0_a,
   input  logic [2*WIDTH-1:0] i_req0_b,
   input  logic               i_req0_cin,
   input  logic               i_req0_wide,
   input  logic               i_req1_valid,
   output logic               o_req1_ready,
   input  logic [2*WIDTH-1:0] i_req1_a,
   input  logic [2*WIDTH-1:0] i_req1_b,
   input  logic               i_req1_cin,
   input  logic               i_req1_wide,
   output logic               o_add_valid,
   output logic [WIDTH-1:0]   o_add_a,
   output logic [WIDTH-1:0]   o_add_b,
   output logic               o_add_cin,
   input  logic [WIDTH-1:0]   i_add_sum,
   input  logic               i_add_cout,
   output logic               o_rsp_valid,
   output logic               o_rsp_id,
   output logic [2*WIDTH-1:0] o_rsp_sum,
   output logic               o_rsp_cout
);

   typedef struct packed {
      logic valid;
      logic id;
      logic wide;
      logic half;
   } tag_t;

`ifdef KS_ADD_SCHED_WIDE_EN
   typedef enum logic [1:0] {ISSUE, WIDE_WAIT, WIDE_HI} state_t;
`else
   typedef enum logic [0:0] {ISSUE = 1'b0} state_t;
`endif

   state_t             state_q, state_d;
   logic               last_q;
   tag_t               tag_q [0:LAT];
   tag_t               tag_exit, issue_tag;
   logic               grant_id, accept, sel_cin, sel_wide;
   logic [2*WIDTH-1:0] sel_a, sel_b;
   logic               issue_go, issue_cin;
   logic [WIDTH-1:0]   issue_a, issue_b;
   logic               exit_lo, exit_rsp;

   // On a tie the requester not granted last wins; a lone requester always wins.
   assign grant_id     = (i_req0_valid & i_req1_valid) ? ~last_q : i_req1_valid;
   assign accept       = (state_q == ISSUE) & (i_req0_valid | i_req1_valid);
   assign o_req0_ready = accept & ~grant_id;
   assign o_req1_ready = accept & grant_id;
   assign sel_a        = grant_id ? i_req1_a   : i_req0_a;
   assign sel_b        = grant_id ? i_req1_b   : i_req0_b;
   assign sel_cin      = grant_id ? i_req1_cin : i_req0_cin;

`ifdef KS_ADD_SCHED_WIDE_EN
   logic [WIDTH-1:0] hi_a_q, hi_b_q, lo_q;
   assign sel_wide = grant_id ? i_req1_wide : i_req0_wide;
`else
   logic unused_wide;
   assign sel_wide    = 1'b0;
   assign unused_wide = ^{i_req0_a[2*WIDTH-1:WIDTH], i_req0_b[2*WIDTH-1:WIDTH],
                          i_req1_a[2*WIDTH-1:WIDTH], i_req1_b[2*WIDTH-1:WIDTH],
                          i_req0_wide, i_req1_wide};
`endif

   assign tag_exit = tag_q[LAT];
   assign exit_lo  = tag_exit.valid & tag_exit.wide & ~tag_exit.half;
   assign exit_rsp = tag_exit.valid & ~exit_lo;

   always_comb begin
      issue_go  = accept;
      issue_a   = sel_a[WIDTH-1:0];
      issue_b   = sel_b[WIDTH-1:0];
      issue_cin = sel_cin;
      issue_tag = {accept, grant_id, sel_wide, 1'b0};
`ifdef KS_ADD_SCHED_WIDE_EN
      // High half is registered on the low-half exit edge, so WIDE_HI is the cycle it is on the port.
      if ((state_q == WIDE_WAIT) && exit_lo) begin
         issue_go  = 1'b1;
         issue_a   = hi_a_q;
         issue_b   = hi_b_q;
         issue_cin = i_add_cout;
         issue_tag = {1'b1, tag_exit.id, 1'b1, 1'b1};
      end
`endif
   end

   always_comb begin
      state_d = state_q;
`ifdef KS_ADD_SCHED_WIDE_EN
      case (state_q)
         ISSUE:     if (accept && sel_wide) state_d = WIDE_WAIT;
         WIDE_WAIT: if (exit_lo) state_d = WIDE_HI;
         WIDE_HI:   state_d = ISSUE;
         default:   state_d = ISSUE;
      endcase
`endif
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ISSUE;
         last_q      <= 1'b1;
         o_add_valid <= 1'b0;
         o_add_a     <= '0;
         o_add_b     <= '0;
         o_add_cin   <= 1'b0;
         for (int unsigned i = 0; i <= LAT; i++) tag_q[i] <= '0;
         o_rsp_valid <= 1'b0;
         o_rsp_id    <= 1'b0;
         o_rsp_sum   <= '0;
         o_rsp_cout  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) last_q <= grant_id;
         o_add_valid <= issue_go;
         if (issue_go) begin
            o_add_a   <= issue_a;
            o_add_b   <= issue_b;
            o_add_cin <= issue_cin;
         end
         tag_q[0] <= issue_tag;
         for (int unsigned i = 1; i <= LAT; i++) tag_q[i] <= tag_q[i-1];
         o_rsp_valid <= exit_rsp;
         if (exit_rsp) begin
            o_rsp_id   <= tag_exit.id;
            o_rsp_cout <= i_add_cout;
`ifdef KS_ADD_SCHED_WIDE_EN
            o_rsp_sum  <= tag_exit.half ? {i_add_sum, lo_q} : {{WIDTH{1'b0}}, i_add_sum};
`else
            o_rsp_sum  <= {{WIDTH{1'b0}}, i_add_sum};
`endif
         end
      end
   end

`ifdef KS_ADD_SCHED_WIDE_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         hi_a_q <= '0;
         hi_b_q <= '0;
         lo_q   <= '0;
      end else begin
         if (accept && sel_wide) begin
            hi_a_q <= sel_a[2*WIDTH-1:WIDTH];
            hi_b_q <= sel_b[2*WIDTH-1:WIDTH];
         end
         if ((state_q == WIDE_WAIT) && exit_lo) lo_q <= i_add_sum;
      end
   end
`endif

endmodule

// File: tb/tb_ks_add_sched.sv
// Directed self-checking bench for ks_add_sched with a behavioural LAT-cycle adder.
// Wide-op vectors run only when KS_ADD_SCHED_WIDE_EN is defined.
module tb_ks_add_sched;
   localparam int unsigned WIDTH = 24;
   localparam int unsigned LAT   = 3;

   logic clk = 1'b0;
   logic rst;
   logic req0_valid, req0_ready, req0_cin, req0_wide;
   logic req1_valid, req1_ready, req1_cin, req1_wide;
   logic [2*WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic add_valid, add_cin, add_cout;
   logic [WIDTH-1:0] add_a, add_b, add_sum;
   logic rsp_valid, rsp_id, rsp_cout;
   logic [2*WIDTH-1:0] rsp_sum;

   ks_add_sched #(.WIDTH(WIDTH), .LAT(LAT)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_a(req0_a),
      .i_req0_b(req0_b), .i_req0_cin(req0_cin), .i_req0_wide(req0_wide),
      .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_a(req1_a),
      .i_req1_b(req1_b), .i_req1_cin(req1_cin), .i_req1_wide(req1_wide),
      .o_add_valid(add_valid), .o_add_a(add_a), .o_add_b(add_b), .o_add_cin(add_cin),
      .i_add_sum(add_sum), .i_add_cout(add_cout),
      .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_sum(rsp_sum), .o_rsp_cout(rsp_cout)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // External adder: result visible LAT cycles after the operands, junk otherwise.
   logic [WIDTH:0] pipe_sum [0:LAT-1];
   logic           pipe_v   [0:LAT-1];
   always @(posedge clk) begin
      pipe_v[0]   <= add_valid;
      pipe_sum[0] <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
      for (int i = 1; i < LAT; i++) begin
         pipe_v[i]   <= pipe_v[i-1];
         pipe_sum[i] <= pipe_sum[i-1];
      end
   end
   assign add_sum  = pipe_v[LAT-1] ? pipe_sum[LAT-1][WIDTH-1:0] : 24'h5A5A5A;
   assign add_cout = pipe_v[LAT-1] ? pipe_sum[LAT-1][WIDTH] : 1'b1;

   typedef struct {
      logic              id;
      logic [2*WIDTH-1:0] sum;
      logic              cout;
      int unsigned       edge_n;
   } rsp_t;
   rsp_t rsp_q[$];

   // Record each response with the clock edge at which it is sampled.
   always @(negedge clk) begin
      if (rsp_valid) rsp_q.push_back('{rsp_id, rsp_sum, rsp_cout, cyc + 1});
   end

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_wide  = 1'b0; req1_wide  = 1'b0;
   endtask

   task automatic expect_rsp(input string tag, input logic id, input logic [2*WIDTH-1:0] sum,
                             input logic cout, input int unsigned edge_n);
      rsp_t r;
      for (int i = 0; i < 40 && rsp_q.size() == 0; i++) @(negedge clk);
      if (rsp_q.size() == 0) begin
         chk({tag, "_timeout"}, 64'(0), 64'(1));
         return;
      end
      r = rsp_q.pop_front();
      chk({tag, "_id"},   64'(r.id),     64'(id));
      chk({tag, "_sum"},  64'(r.sum),    64'(sum));
      chk({tag, "_cout"}, 64'(r.cout),   64'(cout));
      chk({tag, "_edge"}, 64'(r.edge_n), 64'(edge_n));
   endtask

   int unsigned t, t2;

   initial begin
      rst = 1'b1;
      idle();
      req0_a = '0; req0_b = '0; req0_cin = 1'b0;
      req1_a = '0; req1_b = '0; req1_cin = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_add_valid", 64'(add_valid), 64'(0));
      chk("rst_add_a",     64'(add_a),     64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_sum",   64'(rsp_sum),   64'(0));
      rst = 1'b0;
      @(negedge clk);

      // Single narrow op from requester 0
      req0_valid = 1'b1; req0_a = 48'h000000_000FFF; req0_b = 48'h1; req0_cin = 1'b0;
      #1;
      chk("t1_rdy0", 64'(req0_ready), 64'(1));
      chk("t1_rdy1", 64'(req1_ready), 64'(0));
      t = cyc + 1;
      @(negedge clk);
      idle();
      chk("t1_add_valid", 64'(add_valid), 64'(1));
      chk("t1_add_a",     64'(add_a),     64'(24'h000FFF));
      chk("t1_add_b",     64'(add_b),     64'(24'h000001));
      expect_rsp("t1", 1'b0, 48'h000000_001000, 1'b0, t + LAT + 2);

      // Carry out from requester 1; upper operand bits of a narrow op are ignored
      @(negedge clk);
      req1_valid = 1'b1; req1_a = 48'hABCDEF_FFFFFF; req1_b = 48'h1; req1_cin = 1'b0;
      #1;
      chk("carry_rdy1", 64'(req1_ready), 64'(1));
      t = cyc + 1;
      @(negedge clk);
      idle();
      expect_rsp("carry", 1'b1, 48'h0, 1'b1, t + LAT + 2);

      // Tie for four cycles: grants alternate starting with requester 0
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 48'h111; req0_b = 48'h1; req0_cin = 1'b0;
      req1_valid = 1'b1; req1_a = 48'h222; req1_b = 48'h2; req1_cin = 1'b1;
      t = cyc + 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("tie%0d_rdy0", k), 64'(req0_ready), 64'(k % 2 == 0));
         chk($sformatf("tie%0d_rdy1", k), 64'(req1_ready), 64'(k % 2 == 1));
         @(negedge clk);
      end
      idle();
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0)
            expect_rsp($sformatf("tie%0d", k), 1'b0, 48'h112, 1'b0, t + k + LAT + 2);
         else
            expect_rsp($sformatf("tie%0d", k), 1'b1, 48'h225, 1'b0, t + k + LAT + 2);
      end

      // Reset with two narrow ops in flight: nothing may come out
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 48'h10; req0_b = 48'h20; req0_cin = 1'b0;
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 48'h30; req1_b = 48'h40; req1_cin = 1'b0;
      @(negedge clk);
      idle();
      rst = 1'b1;
      #1;
      chk("midrst_add_valid", 64'(add_valid), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("midrst_no_rsp", 64'(rsp_q.size()), 64'(0));

      // After reset requester 0 wins the first tie
      req0_valid = 1'b1; req0_a = 48'h7; req0_b = 48'h8; req0_cin = 1'b1;
      req1_valid = 1'b1; req1_a = 48'h9; req1_b = 48'h9; req1_cin = 1'b0;
      #1;
      chk("postrst_rdy0", 64'(req0_ready), 64'(1));
      chk("postrst_rdy1", 64'(req1_ready), 64'(0));
      t = cyc + 1;
      @(negedge clk);
      idle();
      expect_rsp("postrst", 1'b0, 48'h10, 1'b0, t + LAT + 2);

`ifdef KS_ADD_SCHED_WIDE_EN
      // Wide op: carry from the low pass feeds the high pass; a waiting narrow op is held off
      @(negedge clk);
      req0_valid = 1'b1; req0_wide = 1'b1;
      req0_a = 48'h000001_FFFFFF; req0_b = 48'h000000_000001; req0_cin = 1'b0;
      #1;
      chk("wide_rdy0", 64'(req0_ready), 64'(1));
      t = cyc + 1;
      @(negedge clk);
      idle();
      req1_valid = 1'b1; req1_a = 48'h5; req1_b = 48'h6; req1_cin = 1'b0;
      for (int i = 0; i <= LAT + 1; i++) begin
         #1;
         chk($sformatf("wide_hold%0d_rdy0", i), 64'(req0_ready), 64'(0));
         chk($sformatf("wide_hold%0d_rdy1", i), 64'(req1_ready), 64'(0));
         if (i == 0) chk("wide_lo_a", 64'(add_a), 64'(24'hFFFFFF));
         if (i == LAT + 1) begin
            chk("wide_hi_valid", 64'(add_valid), 64'(1));
            chk("wide_hi_a",     64'(add_a),     64'(24'h000001));
            chk("wide_hi_b",     64'(add_b),     64'(24'h000000));
            chk("wide_hi_cin",   64'(add_cin),   64'(1));
         end
         @(negedge clk);
      end
      #1;
      chk("wide_release_rdy1", 64'(req1_ready), 64'(1));
      t2 = cyc + 1;
      @(negedge clk);
      idle();
      expect_rsp("wide", 1'b0, 48'h000002_000000, 1'b0, t + 2*LAT + 3);
      expect_rsp("after_wide", 1'b1, 48'hB, 1'b0, t2 + LAT + 2);

      // Narrow op in flight ahead of a wide op
      @(negedge clk);
      req1_valid = 1'b1; req1_a = 48'h10; req1_b = 48'h20; req1_cin = 1'b0;
      #1;
      chk("mix_rdy1", 64'(req1_ready), 64'(1));
      t = cyc + 1;
      @(negedge clk);
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_wide = 1'b1;
      req0_a = 48'h000003_800000; req0_b = 48'h000004_800000; req0_cin = 1'b0;
      #1;
      chk("mix_rdy0", 64'(req0_ready), 64'(1));
      t2 = cyc + 1;
      @(negedge clk);
      idle();
      expect_rsp("mix_narrow", 1'b1, 48'h30, 1'b0, t + LAT + 2);
      expect_rsp("mix_wide", 1'b0, 48'h000008_000000, 1'b0, t2 + 2*LAT + 3);
`else
      // Wide flag is ignored: only the low halves are added
      @(negedge clk);
      req0_valid = 1'b1; req0_wide = 1'b1;
      req0_a = 48'h000005_000001; req0_b = 48'h000007_000002; req0_cin = 1'b0;
      #1;
      chk("nowide_rdy0", 64'(req0_ready), 64'(1));
      t = cyc + 1;
      @(negedge clk);
      idle();
      #1;
      chk("nowide_rdy_next", 64'(req0_ready), 64'(0));
      expect_rsp("nowide", 1'b0, 48'h000000_000003, 1'b0, t + LAT + 2);
`endif

      repeat (15) @(negedge clk);
      chk("no_extra_rsp", 64'(rsp_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
